// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone B3 block RAM slave with
// registered-feedback CTI/BTE bursts and optional ROM mode.
module wb_bram_burst #(
  parameter int DATA_W    = 32,
  parameter int ADR_W     = 11,
  parameter     MEM_FILE  = "none",
  parameter int READ_ONLY = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic              wb_ack_o,
  output logic [DATA_W-1:0] wb_dat_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int LSB   = $clog2(SEL_W);
  localparam int WA_W  = ADR_W - LSB;
  localparam int DEPTH = 2 ** WA_W;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIC,
    BURST
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [WA_W-1:0] wa;
  logic [WA_W-1:0] cur;
  logic [WA_W-1:0] na;
  logic [WA_W-1:0] rd_adr;
  logic [DATA_W-1:0] dat;
  logic req;
  logic ack;
  logic ack_nx;
  logic load;
  logic commit;
  logic start;
  logic adv;
  logic wr_en;
  logic unused_adr;

  assign req = wb_cyc_i & wb_stb_i;
  assign wa  = wb_adr_i[ADR_W-1:LSB];
  assign unused_adr = ^{wb_adr_i[31:ADR_W], wb_adr_i[LSB-1:0]};

  assign wb_ack_o = ack;
  assign wb_dat_o = dat;

  function automatic logic [WA_W-1:0] inc(
    input logic [WA_W-1:0] a,
    input logic [1:0]      bte
  );
    logic [WA_W-1:0] lin;
    logic [WA_W-1:0] msk;
    int wb;
    lin = a + WA_W'(1);
    case (bte)
      2'b01:   wb = 2;
      2'b10:   wb = 3;
      2'b11:   wb = 4;
      default: wb = 0;
    endcase
    if (wb > WA_W) wb = 0;
    for (int i = 0; i < WA_W; i++)
      msk[i] = (wb == 0) || (i < wb);
    return (a & ~msk) | (lin & msk);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    load     = 1'b0;
    commit   = 1'b0;
    start    = 1'b0;
    adv      = 1'b0;
    rd_adr   = wa;
    unique case (state)
      IDLE: begin
        if (req) begin
          load   = 1'b1;
          ack_nx = 1'b1;
          if (wb_cti_i == 3'b010) begin
            start    = 1'b1;
            state_nx = BURST;
          end else begin
            state_nx = CLASSIC;
          end
        end
      end
      CLASSIC: begin
        commit   = req;
        state_nx = IDLE;
      end
      BURST: begin
        state_nx = IDLE;
        if (req && (wa == cur)) begin
          commit = 1'b1;
          if (wb_cti_i != 3'b111) begin
            load     = 1'b1;
            rd_adr   = na;
            ack_nx   = 1'b1;
            adv      = 1'b1;
            state_nx = BURST;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack <= 1'b0;
      dat <= '0;
      cur <= '0;
      na  <= '0;
    end else begin
      ack <= ack_nx;
      if (load) dat <= mem[rd_adr];
      if (start) begin
        cur <= wa;
        na  <= inc(wa, wb_bte_i);
      end else if (adv) begin
        cur <= na;
        na  <= inc(na, wb_bte_i);
      end
    end
  end

  assign wr_en = commit && wb_we_i && (READ_ONLY == 0);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < SEL_W; i++)
        if (wb_sel_i[i])
          mem[wa][8*i +: 8] <= wb_dat_i[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// tb_wb_bram_burst: random and directed Wishbone traffic
// against a word-array model with a queued scoreboard.
module tb_wb_bram_burst;

  localparam int DEPTH    = 512;
  localparam int RO_DEPTH = 8;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        bus_ro = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;

  logic        ack0;
  logic        ack1;
  logic [31:0] dat0;
  logic [31:0] dat1;
  logic        cyc0;
  logic        cyc1;
  logic        ack_s;
  logic [31:0] dat_s;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] ro_m [RO_DEPTH];
  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          ro_learn = 1'b0;
  logic        req0_q = 1'b0;
  logic        req1_q = 1'b0;

  assign cyc0  = cyc & ~bus_ro;
  assign cyc1  = cyc & bus_ro;
  assign ack_s = bus_ro ? ack1 : ack0;
  assign dat_s = bus_ro ? dat1 : dat0;

  always #5 clk = ~clk;

  wb_bram_burst #(
    .DATA_W(32), .ADR_W(11), .MEM_FILE("none"), .READ_ONLY(0)
  ) u_rw (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
    .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(ack0), .wb_dat_o(dat0)
  );

  wb_bram_burst #(
    .DATA_W(32), .ADR_W(5), .MEM_FILE("none"), .READ_ONLY(1)
  ) u_ro (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
    .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(ack1), .wb_dat_o(dat1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int nxt(input int a, input logic [1:0] bt,
                             input int depth);
    int n;
    n = (bt == 2'b00) ? 1 : (bt == 2'b01) ? 4 : (bt == 2'b10) ? 8 : 16;
    if (n == 1 || depth < n) return (a + 1) % depth;
    return (a / n) * n + ((a % n) + 1) % n;
  endfunction

  function automatic logic [31:0] badr(input int a, input int aw);
    logic [31:0] m;
    m = (32'd1 << aw) - 32'd1;
    return ($urandom & ~m) | (32'(a) << 2) | ($urandom & 32'd3);
  endfunction

  always @(posedge clk) begin
    req0_q <= cyc0 & stb;
    req1_q <= cyc1 & stb;
  end

  always @(negedge clk) begin
    if (ack0) chk("ack0_after_req", req0_q, 1'b1);
    if (ack1) chk("ack1_after_req", req1_q, 1'b1);
    if (ack_s && cyc && stb) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_ack: ack with no pending beat, adr %h", adr);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.kind == 1) chk("rdata", dat_s, mon_e.d);
        else if (mon_e.kind == 2) ro_m[mon_e.idx] = dat_s;
      end
    end
  end

  task automatic access(input bit ro, input bit w, input int start,
      input int len, input bit burst, input logic [1:0] bt,
      input int wait_at, input int rst_at, input logic [3:0] s,
      input logic [31:0] wd, input bit rnd);
    int a;
    int a_prev;
    int lat;
    int depth;
    int aw;
    bit fresh;
    logic [2:0] ccti [4];
    ccti = '{3'b000, 3'b001, 3'b111, 3'b100};
    depth = ro ? RO_DEPTH : DEPTH;
    aw = ro ? 5 : 11;
    a = start;
    a_prev = start;
    fresh = 1'b1;
    bus_ro = ro;
    for (int i = 0; i < len; i++) begin
      if (i == wait_at && i != 0) begin
        stb = 1'b0;
        adr = badr(a_prev, aw);
        dat_w = $urandom;
        @(posedge clk); #1;
        chk("ack_drop", ack_s, 1'b0);
        fresh = 1'b1;
      end
      cyc = 1'b1;
      stb = 1'b1;
      we = w;
      sel = s;
      bte = bt;
      adr = badr(a, aw);
      dat_w = rnd ? $urandom : wd;
      if (!burst) cti = ccti[$urandom_range(0, 3)];
      else cti = (i == len - 1) ? 3'b111 : 3'b010;
      if (w) sbq.push_back('{0, a, 32'h0});
      else if (ro && ro_learn) sbq.push_back('{2, a, 32'h0});
      else if (ro) sbq.push_back('{1, a, ro_m[a]});
      else sbq.push_back('{1, a, mem_m[a]});
      lat = 0;
      while (ack_s !== 1'b1 && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("latency", lat, fresh ? 1 : 0);
      if (ack_s !== 1'b1) begin
        cyc = 1'b0;
        stb = 1'b0;
        sbq.delete();
        return;
      end
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", ack_s, 1'b0);
        chk("rst_mid_dat", dat_s, 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        we = 1'b0;
        cti = 3'b000;
        sbq.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (w && !ro) mem_m[a] = merge(mem_m[a], dat_w, s);
      a_prev = a;
      a = burst ? nxt(a, bt, depth) : (a + 1) % depth;
      fresh = !burst;
    end
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    cti = 3'b000;
    chk("ack_end", ack_s, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    int len;
    int bu;
    int wt;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack0", ack0, 1'b0);
    chk("reset_dat0", dat0, 32'h0);
    chk("reset_ack1", ack1, 1'b0);
    chk("reset_dat1", dat1, 32'h0);
    rst_n = 1'b1;

    access(0, 1, 0, DEPTH, 1, 2'b00, -1, -1, 4'hF, 0, 1);

    access(0, 1, 4, 1, 0, 2'b00, -1, -1, 4'b1111, 32'hA5A5_1234, 0);
    access(0, 0, 4, 1, 0, 2'b00, -1, -1, 4'b0000, 0, 0);
    access(0, 1, 4, 1, 0, 2'b00, -1, -1, 4'b0010, 32'hFFFF_FFFF, 0);
    access(0, 0, 4, 1, 0, 2'b00, -1, -1, 4'b0000, 0, 0);

    access(0, 0, 6, 4, 1, 2'b00, -1, -1, 4'h0, 0, 0);
    access(0, 0, DEPTH - 2, 4, 1, 2'b00, -1, -1, 4'h0, 0, 0);
    access(0, 0, 14, 4, 1, 2'b01, -1, -1, 4'h0, 0, 0);
    access(0, 0, 13, 8, 1, 2'b10, -1, -1, 4'h0, 0, 0);
    access(0, 0, 35, 20, 1, 2'b11, -1, -1, 4'h0, 0, 0);

    access(0, 1, 20, 6, 1, 2'b00, 2, -1, 4'hF, 0, 1);
    access(0, 0, 20, 6, 1, 2'b00, 2, -1, 4'h0, 0, 0);
    access(0, 0, 40, 8, 1, 2'b10, 3, -1, 4'h0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      w = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      bu = ($urandom_range(0, 3) != 0) ? 1 : 0;
      wt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : -1;
      access(0, w[0], $urandom_range(0, DEPTH - 1), len, bu[0],
             2'($urandom_range(0, 3)), wt, -1, 4'($urandom), 0, 1);
    end

    access(0, 1, 100, 6, 1, 2'b00, -1, 3, 4'hF, 0, 1);
    access(0, 0, 103, 1, 0, 2'b00, -1, -1, 4'h0, 0, 0);
    access(0, 0, 100, 6, 1, 2'b00, -1, -1, 4'h0, 0, 0);

    ro_learn = 1'b1;
    access(1, 0, 0, RO_DEPTH, 0, 2'b00, -1, -1, 4'h0, 0, 0);
    ro_learn = 1'b0;
    access(1, 1, 0, RO_DEPTH, 1, 2'b00, -1, -1, 4'hF, 0, 1);
    access(1, 0, 5, 10, 1, 2'b11, -1, -1, 4'h0, 0, 0);
    access(1, 1, 3, 1, 0, 2'b00, -1, -1, 4'hF, 32'hDEAD_BEEF, 0);
    access(1, 0, 3, 1, 0, 2'b00, -1, -1, 4'h0, 0, 0);
    access(1, 0, 6, 4, 1, 2'b01, -1, -1, 4'h0, 0, 0);

    access(0, 0, 0, 16, 1, 2'b00, -1, -1, 4'h0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
